cfu_cmd_master: RTL and testbench

CFU_CMD_MASTER -- requirements
Module: cfu_cmd_master

---
 rtl/cfu_master_pkg.sv | 23 ++
 rtl/cfu_req_fifo.sv | 51 +++++
 rtl/cfu_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_cfu_cmd_master.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_master_pkg.sv
// Shared types and constants for the CFU command master.
// Holds the FSM state enum and the queued request layout.
package cfu_master_pkg;

  localparam int CFU_WORD_W = 32;

  localparam logic [CFU_WORD_W-1:0] TIMEOUT_DATA =
    32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELIVER
  } state_t;

  typedef struct packed {
    logic [CFU_WORD_W-1:0] instr;
    logic [CFU_WORD_W-1:0] in0;
    logic [CFU_WORD_W-1:0] in1;
  } req_t;

endpackage

// File: rtl/cfu_req_fifo.sv
// Request queue: power-of-two depth, pointers one bit wider
// than the index so full/empty are told apart by the MSB.
module cfu_req_fifo
  import cfu_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  req_t wr_data,
  input  logic pop,
  output req_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cfu_req_fifo: DEPTH must be a power of two >= 2");
  end

  req_t        mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW + 1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cfu_cmd_master.sv
// Queues CFU requests and runs them one at a time in order.
// CFU_CMD_MASTER_TIMEOUT_EN adds a response timeout.
module cfu_cmd_master
  import cfu_master_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [2:0] ROUNDING       = 3'd0,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instruction,
  input  logic [31:0] req_in0,
  input  logic [31:0] req_in1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_payload_instruction,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  output logic [2:0]  cmd_payload_rounding,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_output,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("cfu_cmd_master: TIMEOUT_CYCLES out of 1..65535");
  end

  state_t state;
  state_t state_nxt;
  req_t   wr_req;
  req_t   head;
  req_t   cmd_q;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  logic   to_hit;

  assign wr_req = '{
    instr: req_instruction,
    in0:   req_in0,
    in1:   req_in1
  };

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  cfu_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_req),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (!fifo_empty) state_nxt = ST_ISSUE;
      ST_ISSUE:
        if (cmd_ready) state_nxt = ST_WAIT;
      ST_WAIT:
        if (rsp_valid || to_hit) state_nxt = ST_DELIVER;
      ST_DELIVER:
        if (res_ready)
          state_nxt = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    res_valid = 1'b0;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE:    pop       = !fifo_empty;
      ST_ISSUE:   cmd_valid = 1'b1;
      ST_WAIT:    rsp_ready = 1'b1;
      ST_DELIVER: begin
        res_valid = 1'b1;
        pop       = res_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // Command register only loads on pop, so it is frozen in ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q    <= '0;
      res_data <= '0;
    end else begin
      if (pop)
        cmd_q <= head;
      if (state == ST_WAIT) begin
        if (rsp_valid)
          res_data <= rsp_payload_output;
        else if (to_hit)
          res_data <= TIMEOUT_DATA;
      end
    end
  end

  assign cmd_payload_instruction = cmd_q.instr;
  assign cmd_payload_inputs_0    = cmd_q.in0;
  assign cmd_payload_inputs_1    = cmd_q.in1;
  assign cmd_payload_rounding    = ROUNDING;

`ifdef CFU_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;
  logic        err_q;

  // Counter rests at zero outside WAIT, so it restarts on entry.
  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      to_cnt <= '0;
    else if (state != ST_WAIT)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (state == ST_WAIT) begin
      if (rsp_valid)
        err_q <= 1'b0;
      else if (to_hit)
        err_q <= 1'b1;
    end
  end

  assign res_err = err_q;
`else
  assign to_hit  = 1'b0;
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfu_cmd_master.sv
// Directed bench for cfu_cmd_master with an in-order
// scoreboard and a simple CFU responder model.
module tb_cfu_cmd_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_instruction = '0;
  logic [31:0] req_in0 = '0;
  logic [31:0] req_in1 = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_payload_instruction;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic [2:0]  cmd_payload_rounding;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_payload_output = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [95:0] cfu_pend = '0;

  always #5 clk = ~clk;

  cfu_cmd_master #(
    .FIFO_DEPTH     (4),
    .ROUNDING       (3'd0),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_instruction         (req_instruction),
    .req_in0                 (req_in0),
    .req_in1                 (req_in1),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_instruction (cmd_payload_instruction),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .cmd_payload_rounding    (cmd_payload_rounding),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_output      (rsp_payload_output),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_data                (res_data),
    .res_err                 (res_err)
  );

  function automatic logic [31:0] cfu_fn(
    input logic [31:0] i,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return i ^ (a + b);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_set(
    input logic [31:0] i,
    input logic [31:0] a,
    input logic [31:0] b
  );
    req_valid       = 1'b1;
    req_instruction = i;
    req_in0         = a;
    req_in1         = b;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_rsp_ready"}, rsp_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Traffic loop: optional new requests, CFU model, scoreboard.
  task automatic run(
    input int n_new,
    input bit rnd,
    input int budget
  );
    int          sent;
    int          cyc;
    logic        hold;
    logic [95:0] held;
    sent = 0;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    while ((sent < n_new || exp_q.size() != 0) && cyc < budget) begin
      if (hold) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_instr", cmd_payload_instruction, held[95:64]);
        chk("hold_in0", cmd_payload_inputs_0, held[63:32]);
        chk("hold_in1", cmd_payload_inputs_1, held[31:0]);
      end
      req_valid = (sent < n_new) &&
                  (!rnd || $urandom_range(0, 3) != 0);
      req_instruction = $urandom;
      req_in0         = $urandom;
      req_in1         = $urandom;
      cmd_ready = !rnd || ($urandom_range(0, 2) != 0);
      res_ready = !rnd || ($urandom_range(0, 2) != 0);
      rsp_valid = rsp_ready &&
                  (!rnd || ($urandom_range(0, 2) != 0));
      rsp_payload_output =
        cfu_fn(cfu_pend[95:64], cfu_pend[63:32], cfu_pend[31:0]);
      if (req_valid && req_ready) begin
        exp_q.push_back(cfu_fn(req_instruction, req_in0, req_in1));
        sent++;
      end
      if (cmd_valid && cmd_ready)
        cfu_pend = {cmd_payload_instruction,
                    cmd_payload_inputs_0,
                    cmd_payload_inputs_1};
      if (res_valid && res_ready) begin
        chk("res_err", res_err, 0);
        if (exp_q.size() == 0)
          chk("res_extra", exp_q.size(), 1);
        else
          chk("res_data", res_data, exp_q.pop_front());
      end
      hold = cmd_valid && !cmd_ready;
      held = {cmd_payload_instruction,
              cmd_payload_inputs_0,
              cmd_payload_inputs_1};
      step();
      cyc++;
    end
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    cmd_ready = 1'b1;
    res_ready = 1'b1;
    chk("run_sent", sent, n_new);
    chk("run_drained", exp_q.size(), 0);
  endtask

  initial begin
    step();
    step();
    chk_idle_outs("rst");
    reset     = 1'b0;
    cmd_ready = 1'b1;
    res_ready = 1'b1;

    // single request, minimum latency
    enq_set(32'h0000_000B, 32'd5, 32'd7);
    step();
    req_valid = 1'b0;
    chk("t1_idle_cmd_valid", cmd_valid, 0);
    step();
    chk("t1_cmd_valid", cmd_valid, 1);
    chk("t1_instr", cmd_payload_instruction, 32'h0000_000B);
    chk("t1_in0", cmd_payload_inputs_0, 5);
    chk("t1_in1", cmd_payload_inputs_1, 7);
    chk("t1_round", cmd_payload_rounding, 0);
    step();
    chk("t1_rsp_ready", rsp_ready, 1);
    chk("t1_cmd_drop", cmd_valid, 0);
    rsp_valid          = 1'b1;
    rsp_payload_output = 32'd12;
    step();
    rsp_valid = 1'b0;
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_data", res_data, 12);
    chk("t1_res_err", res_err, 0);
    chk("t1_rsp_ready_off", rsp_ready, 0);
    step();
    chk("t1_res_done", res_valid, 0);

    // fill the queue behind a stalled command
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      enq_set(32'h100 + k, k, 2 * k);
      exp_q.push_back(cfu_fn(32'h100 + k, k, 2 * k));
      chk("t2_req_ready", req_ready, 1);
      step();
    end
    chk("t2_full", req_ready, 0);
    chk("t2_cmd_valid", cmd_valid, 1);
    chk("t2_cmd_instr", cmd_payload_instruction, 32'h100);
    enq_set(32'h1FF, 32'd9, 32'd9);
    step();
    req_valid = 1'b0;
    chk("t2_refused", req_ready, 0);
    chk("t2_stall_instr", cmd_payload_instruction, 32'h100);
    run(0, 1'b0, 200);
    for (int c = 0; c < 3; c++) begin
      chk("t2_no_extra_cmd", cmd_valid, 0);
      chk("t2_empty", req_ready, 1);
      step();
    end

    // result back-pressure
    cmd_ready = 1'b1;
    res_ready = 1'b0;
    enq_set(32'h300, 32'd1, 32'd2);
    step();
    enq_set(32'h301, 32'd3, 32'd4);
    step();
    req_valid = 1'b0;
    chk("t3_instr_g", cmd_payload_instruction, 32'h300);
    step();
    rsp_valid          = 1'b1;
    rsp_payload_output = 32'hCAFE_0003;
    step();
    rsp_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("t3_res_valid", res_valid, 1);
      chk("t3_res_data", res_data, 32'hCAFE_0003);
      chk("t3_no_cmd", cmd_valid, 0);
      step();
    end
    res_ready = 1'b1;
    exp_q.push_back(cfu_fn(32'h301, 32'd3, 32'd4));
    step();
    chk("t3_next_cmd", cmd_valid, 1);
    chk("t3_instr_h", cmd_payload_instruction, 32'h301);
    run(0, 1'b0, 100);

    // reset while waiting with two requests queued
    enq_set(32'h400, 32'd1, 32'd1);
    step();
    enq_set(32'h401, 32'd2, 32'd2);
    step();
    enq_set(32'h402, 32'd3, 32'd3);
    step();
    req_valid = 1'b0;
    chk("t4_in_wait", rsp_ready, 1);
    reset = 1'b1;
    #1;
    chk_idle_outs("t4_rst");
    step();
    reset              = 1'b0;
    rsp_valid          = 1'b1;
    rsp_payload_output = 32'h1234;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t4_no_res", res_valid, 0);
      chk("t4_no_cmd", cmd_valid, 0);
    end
    rsp_valid = 1'b0;

`ifdef CFU_CMD_MASTER_TIMEOUT_EN
    enq_set(32'h500, 32'd1, 32'd1);
    step();
    req_valid = 1'b0;
    step();
    step();
    for (int c = 0; c < 8; c++) begin
      chk("t5_waiting", rsp_ready, 1);
      chk("t5_no_res", res_valid, 0);
      if (c < 7) step();
    end
    step();
    chk("t5_to_valid", res_valid, 1);
    chk("t5_to_data", res_data, 32'hDEAD_BEEF);
    chk("t5_to_err", res_err, 1);
    step();
    enq_set(32'h501, 32'd1, 32'd1);
    step();
    req_valid = 1'b0;
    step();
    step();
    repeat (7) step();
    chk("t5_tie_wait", rsp_ready, 1);
    rsp_valid          = 1'b1;
    rsp_payload_output = 32'h5555_5555;
    step();
    rsp_valid = 1'b0;
    chk("t5_tie_valid", res_valid, 1);
    chk("t5_tie_data", res_data, 32'h5555_5555);
    chk("t5_tie_err", res_err, 0);
    step();
`else
    enq_set(32'h500, 32'd1, 32'd1);
    step();
    req_valid = 1'b0;
    step();
    step();
    repeat (300) step();
    chk("t5_still_wait", rsp_ready, 1);
    chk("t5_no_res", res_valid, 0);
    rsp_valid          = 1'b1;
    rsp_payload_output = 32'h7777_0001;
    step();
    rsp_valid = 1'b0;
    chk("t5_late_data", res_data, 32'h7777_0001);
    chk("t5_late_err", res_err, 0);
    step();
`endif

    // random stalls everywhere
    run(1000, 1'b1, 40000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
